nmt_mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port data memory between NUM_NMT NMT_DEVICE cores.
- Each core raises a load or store request (command, address, store data). The arbiter grants one core at a time, drives the memory port, waits the fixed memory latency, and returns load data or a store acknowledgement to the granted core.
- Sits between the NMT_DEVICE array and the shared memory in the system top. Only one transaction is in flight at a time.

---
 rtl/nmt_mem_arbiter_pkg.sv | 22 ++
 rtl/nmt_mem_arbiter_rr_pick.sv | 31 +++
 rtl/nmt_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_nmt_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmt_mem_arbiter_pkg.sv
// Shared types for the NMT memory arbiter: command encodings, FSM states,
// and default datapath widths.
package nmt_mem_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/nmt_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(ptr) + k) % N);
      if (!any && req_vec[j]) begin
        any       = 1'b1;
        win_idx   = j;
        win_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmt_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_NMT cores;
// one transaction in flight, fixed memory latency MEM_LAT.
module nmt_mem_arbiter
  import nmt_mem_pkg::*;
#(
  parameter int NUM_NMT = 4,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_NMT-1:0]        req,
  input  logic [2*NUM_NMT-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_NMT-1:0] req_addr,
  input  logic [WORD_W*NUM_NMT-1:0] req_wdata,
  output logic [NUM_NMT-1:0]        gnt,
  output logic [NUM_NMT-1:0]        resp_valid,
  output logic [WORD_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_NMT);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  cmd_t             cmd_q;
  logic [2:0]       cnt;

  logic [NUM_NMT-1:0] cand;
  logic [NUM_NMT-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  cmd_t               pick_cmd;

  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NUM_NMT; i++)
      cand[i] = req[i] && (req_cmd[2*i +: 2] != CMD_NOP);
  end

  always_comb begin
    pick_cmd = cmd_t'(req_cmd[2*pick_idx +: 2]);
  end

  rr_pick #(.N(NUM_NMT), .IDX_W(IDX_W)) u_pick (
    .req_vec (cand),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign busy = (state != IDLE);

  // Outputs are registered on the edge that enters the state they belong to,
  // so gnt/mem_en are visible for exactly the ISSUE cycle and resp_* for RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      win_idx    <= '0;
      cmd_q      <= CMD_NOP;
      cnt        <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            win_idx   <= pick_idx;
            cmd_q     <= pick_cmd;
            mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[pick_idx*WORD_W +: WORD_W];
            gnt       <= pick_oh;
            mem_en    <= (pick_cmd != CMD_ILL);
            mem_we    <= (pick_cmd == CMD_STORE);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ptr   <= (win_idx == IDX_W'(NUM_NMT - 1)) ? '0 : win_idx + 1'b1;
          cnt   <= 3'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (cmd_q == CMD_LOAD) resp_rdata <= mem_rdata;
            resp_valid <= NUM_NMT'(1) << win_idx;
            resp_err   <= (cmd_q == CMD_ILL);
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmt_mem_arbiter.sv
// Directed bench for nmt_mem_arbiter: one DUT with MEM_LAT=1, one with MEM_LAT=3.
module tb_nmt_mem_arbiter;
  import nmt_mem_pkg::*;

  logic clk;
  int   n_cmp;
  int   n_bad;

  // DUT A: MEM_LAT = 1
  logic        rst_a;
  logic [3:0]  req_a;
  logic [7:0]  cmd_a;
  logic [39:0] addr_a;
  logic [127:0] wdata_a;
  logic [3:0]  gnt_a, rv_a;
  logic [31:0] rdata_a, mrdata_a, mwdata_a;
  logic        err_a, men_a, mwe_a, busy_a;
  logic [9:0]  maddr_a;

  // DUT B: MEM_LAT = 3
  logic        rst_b;
  logic [3:0]  req_b;
  logic [7:0]  cmd_b;
  logic [39:0] addr_b;
  logic [127:0] wdata_b;
  logic [3:0]  gnt_b, rv_b;
  logic [31:0] rdata_b, mrdata_b, mwdata_b;
  logic        err_b, men_b, mwe_b, busy_b;
  logic [9:0]  maddr_b;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] pb [3];

  nmt_mem_arbiter #(.NUM_NMT(4), .WORD_W(32), .ADDR_W(10), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .req_cmd(cmd_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .gnt(gnt_a), .resp_valid(rv_a), .resp_rdata(rdata_a),
    .resp_err(err_a), .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a),
    .mem_wdata(mwdata_a), .mem_rdata(mrdata_a), .busy(busy_a)
  );

  nmt_mem_arbiter #(.NUM_NMT(4), .WORD_W(32), .ADDR_W(10), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .req_cmd(cmd_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .gnt(gnt_b), .resp_valid(rv_b), .resp_rdata(rdata_b),
    .resp_err(err_b), .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b),
    .mem_wdata(mwdata_b), .mem_rdata(mrdata_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem_a[ld_addr] <= ld_data;
    else if (men_a) begin
      if (mwe_a) mem_a[maddr_a] <= mwdata_a;
      else mrdata_a <= mem_a[maddr_a];
    end
  end

  always @(posedge clk) begin
    if (ld_en) mem_b[ld_addr] <= ld_data;
    else if (men_b) begin
      if (mwe_b) mem_b[maddr_b] <= mwdata_b;
      else pb[0] <= mem_b[maddr_b];
    end
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign mrdata_b = pb[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic set_a(input int i, input logic r, input logic [1:0] c,
                       input logic [9:0] ad, input logic [31:0] wd);
    req_a[i] = r; cmd_a[2*i +: 2] = c; addr_a[10*i +: 10] = ad; wdata_a[32*i +: 32] = wd;
  endtask

  task automatic set_b(input int i, input logic r, input logic [1:0] c,
                       input logic [9:0] ad, input logic [31:0] wd);
    req_b[i] = r; cmd_b[2*i +: 2] = c; addr_b[10*i +: 10] = ad; wdata_b[32*i +: 32] = wd;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if (gnt_a !== 4'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
    n_cmp++; if (rv_a !== 4'b0) begin n_bad++; $display("FAIL reset_rv: got %b want 0000", rv_a); end
    n_cmp++; if ({men_a, mwe_a, busy_a, err_a} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {men_a, mwe_a, busy_a, err_a}); end
    n_cmp++; if (rdata_a !== 32'h0 || maddr_a !== 10'h0 || mwdata_a !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", rdata_a, maddr_a, mwdata_a); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    preload(10'h005, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) preload(10'(32'h20 + i), 32'hA000_0000 + 32'(i));
    preload(10'h007, 32'hCAFEF00D);
    preload(10'h000, 32'hB0B0_0000);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    set_a(2, 1'b1, CMD_LOAD, 10'h005, 32'h0);
    tick();
    n_cmp++; if (gnt_a !== 4'b0100) begin n_bad++; $display("FAIL load_gnt: got %b want 0100", gnt_a); end
    n_cmp++; if ({men_a, mwe_a, busy_a} !== 3'b101) begin n_bad++; $display("FAIL load_issue_ctl: got %b want 101", {men_a, mwe_a, busy_a}); end
    n_cmp++; if (maddr_a !== 10'h005) begin n_bad++; $display("FAIL load_addr: got %h want 005", maddr_a); end
    tick();
    n_cmp++; if ({gnt_a, rv_a, men_a} !== 9'b0) begin n_bad++; $display("FAIL load_wait: got %b want 0", {gnt_a, rv_a, men_a}); end
    set_a(2, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if (rv_a !== 4'b0100 || err_a !== 1'b0) begin n_bad++; $display("FAIL load_resp: got %b err %b want 0100 err 0", rv_a, err_a); end
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata: got %h want deadbeef", rdata_a); end
    tick();
    n_cmp++; if (rv_a !== 4'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL load_idle: got rv %b busy %b want 0000 0", rv_a, busy_a); end
  endtask

  task automatic test_store_load();
    set_a(0, 1'b1, CMD_STORE, 10'h010, 32'h12345678);
    tick();
    n_cmp++; if (gnt_a !== 4'b0001 || {men_a, mwe_a} !== 2'b11) begin n_bad++; $display("FAIL store_issue: got %b %b want 0001 11", gnt_a, {men_a, mwe_a}); end
    n_cmp++; if (maddr_a !== 10'h010 || mwdata_a !== 32'h12345678) begin n_bad++; $display("FAIL store_data: got %h %h want 010 12345678", maddr_a, mwdata_a); end
    tick();
    n_cmp++; if ({men_a, mwe_a} !== 2'b00) begin n_bad++; $display("FAIL store_wait_we: got %b want 00", {men_a, mwe_a}); end
    set_a(0, 1'b1, CMD_LOAD, 10'h010, 32'h0);
    tick();
    n_cmp++; if (rv_a !== 4'b0001 || rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL store_resp: got %b %h want 0001 deadbeef", rv_a, rdata_a); end
    tick();
    tick();
    n_cmp++; if (gnt_a !== 4'b0001 || {men_a, mwe_a} !== 2'b10) begin n_bad++; $display("FAIL reload_issue: got %b %b want 0001 10", gnt_a, {men_a, mwe_a}); end
    tick();
    set_a(0, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if (rv_a !== 4'b0001 || rdata_a !== 32'h12345678) begin n_bad++; $display("FAIL reload_rdata: got %b %h want 0001 12345678", rv_a, rdata_a); end
    tick();
  endtask

  task automatic test_nop_ignored();
    set_a(2, 1'b1, CMD_NOP, 10'h005, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (gnt_a !== 4'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL nop_ignored: got gnt %b busy %b want 0000 0", gnt_a, busy_a); end
    end
    set_a(2, 1'b0, CMD_NOP, 10'h0, 32'h0);
  endtask

  task automatic test_all_four();
    logic [3:0] eg, er;
    rst_a = 1'b0; tick(); rst_a = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 1'b1, CMD_LOAD, 10'(32'h20 + i), 32'h0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      eg = (c % 4 == 1) ? 4'(1 << ((c - 1) / 4)) : 4'b0;
      er = (c % 4 == 3) ? 4'(1 << ((c - 3) / 4)) : 4'b0;
      n_cmp++; if (gnt_a !== eg) begin n_bad++; $display("FAIL all4_gnt c%0d: got %b want %b", c, gnt_a, eg); end
      n_cmp++; if (rv_a !== er) begin n_bad++; $display("FAIL all4_rv c%0d: got %b want %b", c, rv_a, er); end
      if (c % 4 == 3) begin
        n_cmp++; if (rdata_a !== 32'hA000_0000 + 32'((c - 3) / 4)) begin n_bad++; $display("FAIL all4_rdata c%0d: got %h want %h", c, rdata_a, 32'hA000_0000 + 32'((c - 3) / 4)); end
      end
      if (c == 15) req_a = 4'b0;
    end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL all4_idle: got busy %b want 0", busy_a); end
  endtask

  task automatic test_starvation();
    set_a(1, 1'b1, CMD_LOAD, 10'h021, 32'h0);
    tick();
    n_cmp++; if (gnt_a !== 4'b0010) begin n_bad++; $display("FAIL starv_first: got %b want 0010", gnt_a); end
    tick(); tick();
    set_a(3, 1'b1, CMD_LOAD, 10'h023, 32'h0);
    tick(); tick();
    n_cmp++; if (gnt_a !== 4'b1000) begin n_bad++; $display("FAIL starv_core3: got %b want 1000", gnt_a); end
    tick();
    set_a(3, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if (rv_a !== 4'b1000 || rdata_a !== 32'hA000_0003) begin n_bad++; $display("FAIL starv_resp3: got %b %h want 1000 a0000003", rv_a, rdata_a); end
    tick(); tick();
    n_cmp++; if (gnt_a !== 4'b0010) begin n_bad++; $display("FAIL starv_core1_again: got %b want 0010", gnt_a); end
    tick();
    set_a(1, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick(); tick();
  endtask

  task automatic test_illegal();
    set_a(1, 1'b1, CMD_ILL, 10'h3FF, 32'h0);
    tick();
    n_cmp++; if (gnt_a !== 4'b0010 || men_a !== 1'b0 || busy_a !== 1'b1) begin n_bad++; $display("FAIL ill_issue: got %b en %b busy %b want 0010 0 1", gnt_a, men_a, busy_a); end
    tick();
    n_cmp++; if (men_a !== 1'b0) begin n_bad++; $display("FAIL ill_wait_en: got %b want 0", men_a); end
    set_a(1, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if (rv_a !== 4'b0010 || err_a !== 1'b1 || men_a !== 1'b0) begin n_bad++; $display("FAIL ill_resp: got %b err %b en %b want 0010 1 0", rv_a, err_a, men_a); end
    n_cmp++; if (rdata_a !== 32'hA000_0001) begin n_bad++; $display("FAIL ill_rdata_hold: got %h want a0000001", rdata_a); end
    tick();
    n_cmp++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL ill_after: got err %b busy %b want 0 0", err_a, busy_a); end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    set_b(2, 1'b1, CMD_LOAD, 10'h007, 32'h0);
    tick();
    n_cmp++; if (gnt_b !== 4'b0100 || men_b !== 1'b1) begin n_bad++; $display("FAIL rst_b_issue: got %b en %b want 0100 1", gnt_b, men_b); end
    tick(); tick();
    rst_b = 1'b0;
    set_b(2, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if ({busy_b, men_b, mwe_b, err_b, gnt_b, rv_b} !== 12'b0 || rdata_b !== 32'h0) begin n_bad++; $display("FAIL rst_b_outputs: got %b %h want 0 0", {busy_b, men_b, mwe_b, err_b, gnt_b, rv_b}, rdata_b); end
    rst_b = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rv_b !== 4'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_b_no_resp: got %b want 0", seen); end
    set_b(0, 1'b1, CMD_LOAD, 10'h000, 32'h0);
    set_b(3, 1'b1, CMD_LOAD, 10'h007, 32'h0);
    tick();
    n_cmp++; if (gnt_b !== 4'b0001) begin n_bad++; $display("FAIL rst_b_ptr: got %b want 0001", gnt_b); end
    tick();
    set_b(0, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick(); tick();
    n_cmp++; if (rv_b !== 4'b0) begin n_bad++; $display("FAIL lat3_early: got %b want 0000", rv_b); end
    tick();
    n_cmp++; if (rv_b !== 4'b0001 || rdata_b !== 32'hB0B0_0000) begin n_bad++; $display("FAIL lat3_resp: got %b %h want 0001 b0b00000", rv_b, rdata_b); end
    set_b(3, 1'b0, CMD_NOP, 10'h0, 32'h0);
    tick();
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL lat3_idle: got %b want 0", busy_b); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    clk = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    req_a = '0; cmd_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; cmd_b = '0; addr_b = '0; wdata_b = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_single_load();
    test_store_load();
    test_nop_ignored();
    test_all_four();
    test_starvation();
    test_illegal();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
